// File: rtl/sem_mem_fifo.sv
// sem_mem_fifo: DEPTH x WIDTH show-ahead FIFO between the semaphore write port and its input port.
// Latency: a word accepted on edge k is the valid head after edge k; a pop takes effect on the edge.
// Backpressure: full drops the new write (OVERWRITE=0) or evicts the oldest (OVERWRITE=1); both set sticky overflow.
//
// Ports:
//   clk_s, rst_s                      clock, async active-high reset
//   sema_write_o_s, sema_data_o_s     write strobe and data from the semaphore core
//   sema_valid_i_s, sema_data_i_s     head entry valid and data (show-ahead)
//   sema_ready_o_s                    consumer accepts the head this cycle
//   sema_full_i_s, sema_is_empty_i_s  occupancy flags
//   sema_count_s                      occupancy 0..DEPTH
//   sema_overflow_s, sema_ovf_clr_s   sticky overflow flag and its synchronous clear
module sem_mem_fifo #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned DEPTH     = 4,
  parameter bit          OVERWRITE = 1'b0,
  parameter int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk_s,
  input  logic             rst_s,
  input  logic             sema_write_o_s,
  input  logic [WIDTH-1:0] sema_data_o_s,
  output logic             sema_full_i_s,
  output logic             sema_is_empty_i_s,
  output logic             sema_valid_i_s,
  output logic [WIDTH-1:0] sema_data_i_s,
  input  logic             sema_ready_o_s,
  output logic [CW-1:0]    sema_count_s,
  output logic             sema_overflow_s,
  input  logic             sema_ovf_clr_s
);

  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;

  logic empty, full, pop, push_acc, ovf_evt, evict, wr_en;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // valid is ~empty, so a pop can never happen on an empty buffer and a
  // write into an empty buffer is never bypassed to the consumer.
  assign pop      = ~empty & sema_ready_o_s;
  // A pop in the same cycle frees a slot, so a full buffer still accepts.
  assign push_acc = sema_write_o_s & (~full | pop);
  assign ovf_evt  = sema_write_o_s & full & ~pop;
  assign evict    = ovf_evt & OVERWRITE;
  assign wr_en    = push_acc | evict;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (wr_en)       wr_ptr_d = ptr_inc(wr_ptr_q);
    // Eviction drops the oldest entry by stepping the read side too.
    if (pop | evict) rd_ptr_d = ptr_inc(rd_ptr_q);

    if (push_acc && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_acc) count_d = count_q - CW'(1);

    // Set has priority over a simultaneous clear.
    if (ovf_evt)             ovf_d = 1'b1;
    else if (sema_ovf_clr_s) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is cleared on reset so the head reads 0 while empty after reset.
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= sema_data_o_s;
    end
  end

  assign sema_full_i_s     = full;
  assign sema_is_empty_i_s = empty;
  assign sema_valid_i_s    = ~empty;
  assign sema_data_i_s     = mem_q[rd_ptr_q];
  assign sema_count_s      = count_q;
  assign sema_overflow_s   = ovf_q;

endmodule

// File: tb/tb_sem_mem_fifo.sv
// Bench for sem_mem_fifo: one instance per full-buffer policy, driven by shared stimulus
// and compared each cycle against queue-based reference models.
module tb_sem_mem_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic         clk_s = 1'b0;
  logic         rst_s = 1'b1;
  logic         wr_i  = 1'b0;
  logic [W-1:0] wd_i  = '0;
  logic         rdy_i = 1'b0;
  logic         clr_i = 1'b0;

  logic          full0, empty0, vld0, ovf0;
  logic [W-1:0]  dat0;
  logic [CW-1:0] cnt0;
  logic          full1, empty1, vld1, ovf1;
  logic [W-1:0]  dat1;
  logic [CW-1:0] cnt1;

  always #5 clk_s = ~clk_s;

  sem_mem_fifo #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b0)) u_drop (
    .clk_s(clk_s), .rst_s(rst_s),
    .sema_write_o_s(wr_i), .sema_data_o_s(wd_i),
    .sema_full_i_s(full0), .sema_is_empty_i_s(empty0),
    .sema_valid_i_s(vld0), .sema_data_i_s(dat0),
    .sema_ready_o_s(rdy_i), .sema_count_s(cnt0),
    .sema_overflow_s(ovf0), .sema_ovf_clr_s(clr_i)
  );

  sem_mem_fifo #(.WIDTH(W), .DEPTH(D), .OVERWRITE(1'b1)) u_ovw (
    .clk_s(clk_s), .rst_s(rst_s),
    .sema_write_o_s(wr_i), .sema_data_o_s(wd_i),
    .sema_full_i_s(full1), .sema_is_empty_i_s(empty1),
    .sema_valid_i_s(vld1), .sema_data_i_s(dat1),
    .sema_ready_o_s(rdy_i), .sema_count_s(cnt1),
    .sema_overflow_s(ovf1), .sema_ovf_clr_s(clr_i)
  );

  // Reference models: contents oldest-first, plus sticky overflow.
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  bit           m_ovf0, m_ovf1;
  // Heads observed at each pop, for ordering checks.
  logic [W-1:0] seen0[$];
  logic [W-1:0] seen1[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("cnt0",   32'(cnt0),   32'(q0.size()));
    chk("empty0", 32'(empty0), 32'(q0.size() == 0));
    chk("full0",  32'(full0),  32'(q0.size() == D));
    chk("valid0", 32'(vld0),   32'(q0.size() != 0));
    chk("ovf0",   32'(ovf0),   32'(m_ovf0));
    if (q0.size() != 0) chk("head0", 32'(dat0), 32'(q0[0]));
    chk("cnt1",   32'(cnt1),   32'(q1.size()));
    chk("empty1", 32'(empty1), 32'(q1.size() == 0));
    chk("full1",  32'(full1),  32'(q1.size() == D));
    chk("valid1", 32'(vld1),   32'(q1.size() != 0));
    chk("ovf1",   32'(ovf1),   32'(m_ovf1));
    if (q1.size() != 0) chk("head1", 32'(dat1), 32'(q1[0]));
  endtask

  // One clock of the behavioural rules, applied to both policies.
  task automatic model_step(input bit wr, input logic [W-1:0] d, input bit rdy, input bit clr);
    bit was_full, popped, evt;
    // drop policy
    was_full = (q0.size() == D);
    popped   = rdy && (q0.size() != 0);
    if (popped) void'(q0.pop_front());
    evt = wr && was_full && !popped;
    if (wr && !evt) q0.push_back(d);
    if (evt) m_ovf0 = 1'b1; else if (clr) m_ovf0 = 1'b0;
    // overwrite-oldest policy
    was_full = (q1.size() == D);
    popped   = rdy && (q1.size() != 0);
    if (popped) void'(q1.pop_front());
    evt = wr && was_full && !popped;
    if (wr) begin
      if (evt) void'(q1.pop_front());
      q1.push_back(d);
    end
    if (evt) m_ovf1 = 1'b1; else if (clr) m_ovf1 = 1'b0;
  endtask

  // Called at a falling edge: drive inputs, confirm outputs have not reacted
  // combinationally, let one rising edge pass, then compare with the model.
  task automatic step(input bit wr, input logic [W-1:0] d, input bit rdy, input bit clr);
    wr_i = wr; wd_i = d; rdy_i = rdy; clr_i = clr;
    #1;
    check_all();
    if (rdy && q0.size() != 0) seen0.push_back(dat0);
    if (rdy && q1.size() != 0) seen1.push_back(dat1);
    model_step(wr, d, rdy, clr);
    @(negedge clk_s);
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic fill4();
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete();
    m_ovf0 = 1'b0; m_ovf1 = 1'b0;
  endtask

  initial begin
    logic [W-1:0] exp_order [6];
    logic [W-1:0] exp_drop  [4];
    logic [W-1:0] exp_ovw   [4];
    exp_order = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_drop  = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_ovw   = '{8'h22, 8'h33, 8'h44, 8'h99};
    model_reset();

    // Values while reset is held.
    #2;
    chk("rst_cnt", 32'(cnt0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_data", 32'(dat1), 0);
    @(negedge clk_s);
    @(negedge clk_s);
    rst_s = 1'b0;
    check_all();

    // Reset mid-run with three entries held.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    chk("pre_rst_cnt", 32'(cnt0), 3);
    rst_s = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_cnt", 32'(cnt0), 0);
    chk("mid_rst_valid", 32'(vld0), 0);
    chk("mid_rst_empty", 32'(empty1), 1);
    chk("mid_rst_data0", 32'(dat0), 0);
    chk("mid_rst_data1", 32'(dat1), 0);
    chk("mid_rst_ovf", 32'(ovf0), 0);
    @(negedge clk_s);
    rst_s = 1'b0;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("post_rst_head", 32'(dat0), 32'h5A);
    drain();

    // Ordering and pointer wrap with pushes interleaved into pops.
    fill4();
    chk("order_full", 32'(full0), 1);
    chk("order_cnt", 32'(cnt0), 4);
    seen0.delete(); seen1.delete();
    step(1'b1, 8'h55, 1'b1, 1'b0);
    step(1'b1, 8'h66, 1'b1, 1'b0);
    drain();
    chk("order_len", 32'(seen0.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < seen0.size()) chk("order_seq", 32'(seen0[i]), 32'(exp_order[i]));
    chk("order_empty", 32'(empty0), 1);

    // Write while full and stalled: drop vs evict-oldest.
    fill4();
    step(1'b1, 8'h99, 1'b0, 1'b0);
    chk("drop_cnt", 32'(cnt0), 4);
    chk("drop_ovf", 32'(ovf0), 1);
    chk("drop_head", 32'(dat0), 32'h11);
    chk("ovw_cnt", 32'(cnt1), 4);
    chk("ovw_ovf", 32'(ovf1), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("clr_ovf0", 32'(ovf0), 0);
    chk("clr_ovf1", 32'(ovf1), 0);
    seen0.delete(); seen1.delete();
    drain();
    for (int i = 0; i < 4; i++) begin
      if (i < seen0.size()) chk("drop_seq", 32'(seen0[i]), 32'(exp_drop[i]));
      if (i < seen1.size()) chk("ovw_seq", 32'(seen1[i]), 32'(exp_ovw[i]));
    end
    chk("drop_len", 32'(seen0.size()), 4);
    chk("ovw_len", 32'(seen1.size()), 4);

    // Push and pop together when full, then when empty.
    fill4();
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("fullpp_cnt", 32'(cnt0), 4);
    chk("fullpp_ovf0", 32'(ovf0), 0);
    chk("fullpp_ovf1", 32'(ovf1), 0);
    drain();
    step(1'b1, 8'h42, 1'b1, 1'b0);
    chk("emptypp_cnt", 32'(cnt0), 1);
    chk("emptypp_head", 32'(dat0), 32'h42);

    // Overflow set wins over a simultaneous clear.
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("race_ovf0", 32'(ovf0), 1);
    chk("race_ovf1", 32'(ovf1), 1);
    step(1'b0, '0, 1'b0, 1'b1);
    drain();

    // Randomised traffic against the models.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 60), W'($urandom), ($urandom_range(0, 99) < 50),
           ($urandom_range(0, 99) < 10));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sem_mem_fifo.md
# sem_mem_fifo

Parametrised successor to the single-bit semaphore/memory connector. It buffers up to DEPTH words of WIDTH bits written by the semaphore core and presents them back to the semaphore input side through a valid/ready handshake. It adds back-pressure (full), an occupancy count, a sticky overflow flag and a selectable overwrite-oldest mode. It sits between the semaphore write port (sema_write_o_s / sema_data_o_s) and the semaphore input port (sema_valid_i_s / sema_data_i_s / sema_ready_o_s).

## Interface
- WIDTH, default 1: data word width in bits; legal range ≥1.
- DEPTH, default 4: number of storage entries; legal range ≥2, need not be a power of two.
- OVERWRITE, default 0: full-buffer policy. 0 drops the new write; 1 discards the oldest entry and stores the new one.
- CW, derived as $clog2(DEPTH+1): width of the count output.

Ports:
- clk_s  in  1  single clock; all state updates on the rising edge.
- rst_s  in  1  reset, asynchronous, active-high.
- sema_write_o_s  in  1  write strobe from the semaphore.
- sema_data_o_s  in  WIDTH  write data, sampled when sema_write_o_s=1.
- sema_full_i_s  out  1  buffer holds DEPTH entries.
- sema_is_empty_i_s  out  1  buffer holds 0 entries.
- sema_valid_i_s  out  1  head entry available; equals ~sema_is_empty_i_s.
- sema_data_i_s  out  WIDTH  head (oldest) entry; 0 when empty after reset.
- sema_ready_o_s  in  1  consumer accepts the head this cycle.
- sema_count_s  out  CW  current occupancy, 0..DEPTH.
- sema_overflow_s  out  1  sticky flag: a write arrived while full without a simultaneous pop.
- sema_ovf_clr_s  in  1  synchronous clear of sema_overflow_s.

## Operation
- State:
  - Storage array mem[DEPTH].
  - Read pointer rd_ptr and write pointer wr_ptr, each 0..DEPTH-1.
  - Registered count.
  - Registered overflow flag.
- Pointers advance by 1 and wrap from DEPTH-1 to 0.
- Flags and head:
  - Empty = (count==0).
  - Full = (count==DEPTH).
  - sema_data_i_s = mem[rd_ptr], a show-ahead head.
- pop = sema_valid_i_s & sema_ready_o_s. A pop increments rd_ptr.
- push_req = sema_write_o_s.
- Case: not full, or pop in the same cycle → accept the push. Write mem[wr_ptr], increment wr_ptr.
- Case: full, no pop, OVERWRITE=0 → drop the write. Storage, pointers and count are unchanged. Set overflow.
- Case: full, no pop, OVERWRITE=1 → write mem[wr_ptr] and increment both wr_ptr and rd_ptr. Count stays DEPTH. Set overflow.
- Count update: +1 for an accepted push with no pop; −1 for a pop with no push; unchanged for push and pop together, or for neither.
- Pop while empty is impossible because valid=0. ready is ignored while empty.
- Write while empty with ready=1: no bypass. The word is stored and the pop does not occur that cycle.
- Overflow clear:
  - sema_ovf_clr_s=1 clears overflow on the next edge.
  - If an overflow event occurs in the same cycle, set wins and the flag stays 1.
- Reset:
  - rst_s=1 asynchronously forces rd_ptr=0, wr_ptr=0, count=0, overflow=0 and mem[*]=0.
  - Outputs during and after reset: is_empty=1, valid=0, full=0, count=0, data_i=0, overflow=0.
  - Reset asserted mid-transfer discards all contents. The first edge after deassertion behaves as normal operation.

## Timing
- Write-to-valid latency is 1 cycle. A write accepted on edge k gives valid=1 and data_i = that word after edge k.
- Pop takes effect on the edge. The next entry, or valid=0, is visible after that edge.
- Every output is a function of registered state only: no combinational path from any input to any output. full, is_empty, valid and count change only on clk_s edges or asynchronously on rst_s.
- Sustained throughput is 1 push and 1 pop per cycle, including when full, with no bubble.
- Overflow asserts on the edge after the offending write.

## Test plan
- Reset values: assert rst_s mid-run with count=3 → after reset, valid=0, is_empty=1, count=0, data_i=0, overflow=0. The first write afterwards appears as the head.
- Order and wrap-around: WIDTH=8, DEPTH=4, OVERWRITE=0. Write 0x11, 0x22, 0x33, 0x44 with ready=0 → full=1, count=4. Then pop 6 times interleaved with writes 0x55, 0x66 → data_i sequence 0x11, 0x22, 0x33, 0x44, 0x55, 0x66, then empty.
- Drop on full: OVERWRITE=0, full with 0x11..0x44, write 0x99 with ready=0 → count=4, overflow=1, head=0x11, and 0x99 is never output. Pulse sema_ovf_clr_s → overflow=0 next cycle.
- Overwrite mode: OVERWRITE=1, full with 0x11..0x44, write 0x99 → count=4, overflow=1, drained sequence 0x22, 0x33, 0x44, 0x99.
- Simultaneous push and pop:
  - Full with write+ready in one cycle → count stays 4, overflow stays 0, new word enters the tail.
  - Empty with write+ready → no pop; count=1 next cycle.
- Clear/set race: overflow event and sema_ovf_clr_s in the same cycle → overflow=1 after the edge.
